// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default widths for the PWM dead-time leg.
package pwm_pkg;

   localparam int unsigned WIDTH_DEF    = 8;
   localparam int unsigned DT_WIDTH_DEF = 6;

   // Gate-pair FSM states; IDLE and DEAD both keep the gates off.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DEAD = 2'd1,
      HI   = 2'd2,
      LO   = 2'd3
   } state_t;

endpackage

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if: duty-update valid/ready channel into one PWM leg.
interface pwm_deadtime_if import pwm_pkg::*; #(
   parameter int unsigned WIDTH = WIDTH_DEF
) ();

   logic [WIDTH-1:0] duty_in;
   logic             duty_valid;
   logic             duty_ready;

   modport master (output duty_in, output duty_valid, input duty_ready);
   modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/dead_time_gen.sv
// dead_time_gen: complementary gate FSM with a dead-time counter between
// every hand-over of the high and low side.
module dead_time_gen import pwm_pkg::*; #(
   parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                start,
   input  logic                kill,
   input  logic [DT_WIDTH-1:0] dead_time,
   output logic                gate_hi,
   output logic                gate_lo
);

   state_t              state, state_nxt;
   logic [DT_WIDTH-1:0] dt_cnt, dt_cnt_nxt;

   // State, counter and gate registers; gates follow the next state so they
   // are a pure decode of the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         dt_cnt  <= '0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
      end else begin
         state   <= state_nxt;
         dt_cnt  <= dt_cnt_nxt;
         gate_hi <= (state_nxt == HI);
         gate_lo <= (state_nxt == LO);
      end
   end

   // Next-state logic; DEAD always runs at least one cycle and ignores req.
   always_comb begin
      state_nxt  = state;
      dt_cnt_nxt = dt_cnt;
      if (kill) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt  = DEAD;
                  dt_cnt_nxt = dead_time;
               end
            end
            HI: begin
               if (!req) begin
                  state_nxt  = DEAD;
                  dt_cnt_nxt = dead_time;
               end
            end
            LO: begin
               if (req) begin
                  state_nxt  = DEAD;
                  dt_cnt_nxt = dead_time;
               end
            end
            DEAD: begin
               if (dt_cnt != '0) dt_cnt_nxt = dt_cnt - DT_WIDTH'(1);
               if (dt_cnt <= DT_WIDTH'(1)) state_nxt = req ? HI : LO;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: one inverter leg. Double-buffered duty compared against the
// shared period counter, driving a dead-time protected gate pair.
// Optional gate-kill input and sticky flag: define PWM_DEADTIME_FAULT_EN.
module pwm_deadtime import pwm_pkg::*; #(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [WIDTH-1:0]    count,
   input  logic [WIDTH-1:0]    max_count,
   pwm_deadtime_if.slave       duty,
   input  logic [DT_WIDTH-1:0] dead_time,
   output logic                gate_hi,
   output logic                gate_lo,
   output logic                period_start
`ifdef PWM_DEADTIME_FAULT_EN
   ,
   input  logic                fault,
   output logic                fault_latched
`endif
);

   logic             bnd;
   logic             req;
   logic             kill;
   logic [WIDTH-1:0] duty_pend;
   logic [WIDTH-1:0] duty_act;

   assign bnd = enable && (count == max_count);
   assign req = count < duty_act;

   // Duty double buffer: ready low means the pending slot holds a value that
   // is promoted to the active duty at the next boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_pend       <= '0;
         duty_act        <= '0;
         duty.duty_ready <= 1'b1;
      end else if (bnd && !duty.duty_ready) begin
         duty_act        <= duty_pend;
         duty.duty_ready <= 1'b1;
      end else if (duty.duty_valid && duty.duty_ready) begin
         duty_pend       <= duty.duty_in;
         duty.duty_ready <= 1'b0;
      end
   end

   // One-cycle marker for the first cycle of each period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) period_start <= 1'b0;
      else       period_start <= bnd;
   end

`ifdef PWM_DEADTIME_FAULT_EN
   // Sticky fault flag; only reset releases the gates again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      fault_latched <= 1'b0;
      else if (fault) fault_latched <= 1'b1;
   end
   assign kill = fault || fault_latched;
`else
   assign kill = 1'b0;
`endif

   dead_time_gen #(.DT_WIDTH(DT_WIDTH)) u_dtg (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .start     (bnd),
      .kill      (kill),
      .dead_time (dead_time),
      .gate_hi   (gate_hi),
      .gate_lo   (gate_lo)
   );

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed vectors for one PWM leg. Stimulus pushes
// hand-computed per-cycle expectations stamped with the cycle they apply to;
// a monitor pops and compares them after each clock edge.
// Fault tests are built when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime;

   typedef struct {
      int         stamp;
      string      name;
      logic [4:0] val;   // {fault_latched, duty_ready, period_start, gate_lo, gate_hi}
      logic [4:0] mask;
   } exp_t;

   localparam logic [4:0] RST_MASK = 5'b00111;
`ifdef PWM_DEADTIME_FAULT_EN
   localparam logic FM = 1'b1;
`else
   localparam logic FM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] count;
   logic [7:0] max_count = 8'd9;
   logic [5:0] dead_time = 6'd1;
   logic       gate_hi, gate_lo, period_start;
   logic       flt_act;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   string      fname[5] = '{"gate_hi", "gate_lo", "period_start", "duty_ready", "fault_latched"};

   pwm_deadtime_if #(.WIDTH(8)) duty_bus ();

`ifdef PWM_DEADTIME_FAULT_EN
   logic fault = 1'b0;
   logic fault_latched;
   assign flt_act = fault_latched;
`else
   assign flt_act = 1'b0;
`endif

   pwm_deadtime #(.WIDTH(8), .DT_WIDTH(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .count        (count),
      .max_count    (max_count),
      .duty         (duty_bus),
      .dead_time    (dead_time),
      .gate_hi      (gate_hi),
      .gate_lo      (gate_lo),
      .period_start (period_start)
`ifdef PWM_DEADTIME_FAULT_EN
      ,
      .fault        (fault),
      .fault_latched(fault_latched)
`endif
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream period counter shared by all legs.
   always @(posedge clk or posedge reset) begin
      if (reset)       count <= 8'd0;
      else if (enable) count <= (count == max_count) ? 8'd0 : count + 8'd1;
   end

   task automatic push(string name, logic [4:0] val, logic [4:0] mask);
      exp_t e;
      e.stamp = cyc + 1;
      e.name  = name;
      e.val   = val;
      e.mask  = mask;
      sb.push_back(e);
   endtask

   // Push n per-cycle expectations; tables are indexed by the count value.
   task automatic run(int n, logic [9:0] hi_t, logic [9:0] lo_t, logic [9:0] rdy_t,
                      logic flt, logic fm, string name);
      for (int i = 0; i < n; i++) begin
         int nc;
         nc = (count == max_count) ? 0 : int'(count) + 1;
         push(name, {flt, rdy_t[nc], (nc == 0), lo_t[nc], hi_t[nc]}, {fm, 4'hF});
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      push("reset", 5'b0, RST_MASK);
      reset = 1'b1;
      @(negedge clk);
      push("reset", 5'b0, RST_MASK);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Reset asserted just after an edge: gates must already be low at sampling.
   task automatic async_reset();
      push("async_reset", 5'b0, RST_MASK);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      push("async_reset", 5'b0, RST_MASK);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compare every expectation stamped for this cycle.
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(posedge clk);
         #2;
         checks++;
         if (gate_hi && gate_lo) begin
            errors++;
            $display("FAIL overlap cyc=%0d gate_hi=%0b gate_lo=%0b required not both 1",
                     cyc, gate_hi, gate_lo);
         end
         act = {flt_act, duty_bus.duty_ready, period_start, gate_lo, gate_hi};
         while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            e = sb.pop_front();
            if (e.stamp != cyc) begin
               checks++;
               errors++;
               $display("FAIL %s stale stamp=%0d cyc=%0d", e.name, e.stamp, cyc);
            end else begin
               for (int b = 0; b < 5; b++) begin
                  if (e.mask[b]) begin
                     checks++;
                     if (act[b] !== e.val[b]) begin
                        errors++;
                        $display("FAIL %s cyc=%0d count=%0d %s actual=%0b required=%0b",
                                 e.name, cyc, count, fname[b], act[b], e.val[b]);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      duty_bus.duty_in    = 8'd0;
      duty_bus.duty_valid = 1'b0;
      @(negedge clk);

      // No duty written: off until first boundary, one DEAD cycle, then LO.
      dead_time = 6'd1;
      do_reset();
      run(9,  10'h000, 10'h000, 10'h3FF, 1'b0, FM, "idle");
      run(10, 10'h000, 10'h3FE, 10'h3FF, 1'b0, FM, "first_bnd");
      run(10, 10'h000, 10'h3FF, 10'h3FF, 1'b0, FM, "lo_hold");

      // Duty 4, dead time 3.
      dead_time = 6'd3;
      do_reset();
      duty_bus.duty_in = 8'd4; duty_bus.duty_valid = 1'b1;
      run(1,  10'h000, 10'h000, 10'h000, 1'b0, FM, "dt3_p0");
      duty_bus.duty_valid = 1'b0;
      run(8,  10'h000, 10'h000, 10'h000, 1'b0, FM, "dt3_p0");
      run(10, 10'b0000011000, 10'b1100000000, 10'h3FF, 1'b0, FM, "dt3_p1");
      run(20, 10'b0000010000, 10'b1100000001, 10'h3FF, 1'b0, FM, "dt3_steady");

      // Mid-period write of 7, second write of 5 stalled until ready returns.
      run(3,  10'b0000010000, 10'b1100000001, 10'b0000000111, 1'b0, FM, "hs_p1");
      duty_bus.duty_in = 8'd7; duty_bus.duty_valid = 1'b1;
      run(1,  10'b0000010000, 10'b1100000001, 10'b0000000111, 1'b0, FM, "hs_p1");
      duty_bus.duty_in = 8'd5;
      run(6,  10'b0000010000, 10'b1100000001, 10'b0000000111, 1'b0, FM, "hs_stall");
      run(2,  10'b0011110000, 10'b0000000001, 10'b0000000001, 1'b0, FM, "hs_p2");
      duty_bus.duty_valid = 1'b0;
      run(8,  10'b0011110000, 10'b0000000001, 10'b0000000001, 1'b0, FM, "hs_p2");
      run(10, 10'b0000111110, 10'b1000000000, 10'h3FF, 1'b0, FM, "hs_p3");
      run(10, 10'b0000110000, 10'b1000000001, 10'h3FF, 1'b0, FM, "hs_p4");

      // Duty 12 > max_count: continuous HI; then duty 0: continuous LO.
      dead_time = 6'd2;
      do_reset();
      duty_bus.duty_in = 8'd12; duty_bus.duty_valid = 1'b1;
      run(1,  10'h000, 10'h000, 10'h000, 1'b0, FM, "full_p0");
      duty_bus.duty_valid = 1'b0;
      run(8,  10'h000, 10'h000, 10'h000, 1'b0, FM, "full_p0");
      run(10, 10'b1111111100, 10'h000, 10'h3FF, 1'b0, FM, "full_p1");
      run(4,  10'h3FF, 10'h000, 10'b0000001111, 1'b0, FM, "full_p2");
      duty_bus.duty_in = 8'd0; duty_bus.duty_valid = 1'b1;
      run(1,  10'h3FF, 10'h000, 10'b0000001111, 1'b0, FM, "full_p2");
      duty_bus.duty_valid = 1'b0;
      run(5,  10'h3FF, 10'h000, 10'b0000001111, 1'b0, FM, "full_p2");
      run(10, 10'b0000000001, 10'b1111111000, 10'h3FF, 1'b0, FM, "zero_p3");
      run(10, 10'h000, 10'h3FF, 10'h3FF, 1'b0, FM, "zero_hold");

      // Dead time 0: exactly one both-off cycle per hand-over.
      dead_time = 6'd0;
      do_reset();
      duty_bus.duty_in = 8'd4; duty_bus.duty_valid = 1'b1;
      run(1,  10'h000, 10'h000, 10'h000, 1'b0, FM, "dt0_p0");
      duty_bus.duty_valid = 1'b0;
      run(8,  10'h000, 10'h000, 10'h000, 1'b0, FM, "dt0_p0");
      run(10, 10'b0000011110, 10'b1111000000, 10'h3FF, 1'b0, FM, "dt0_p1");
      run(10, 10'b0000011100, 10'b1111000001, 10'h3FF, 1'b0, FM, "dt0_p2");

      // Reset while HI with a pending duty of 8: gates drop, pending is lost.
      run(2,  10'b0000011100, 10'b1111000001, 10'b0000000011, 1'b0, FM, "dt0_p3");
      duty_bus.duty_in = 8'd8; duty_bus.duty_valid = 1'b1;
      run(1,  10'b0000011100, 10'b1111000001, 10'b0000000011, 1'b0, FM, "dt0_p3");
      duty_bus.duty_valid = 1'b0;
      async_reset();
      run(9,  10'h000, 10'h000, 10'h3FF, 1'b0, FM, "post_rst_p0");
      run(10, 10'h000, 10'h3FE, 10'h3FF, 1'b0, FM, "post_rst_p1");
      run(10, 10'h000, 10'h3FF, 10'h3FF, 1'b0, FM, "post_rst_p2");

`ifdef PWM_DEADTIME_FAULT_EN
      // Fault while HI: gates off next edge, flag sticky across boundaries.
      dead_time = 6'd2;
      do_reset();
      duty_bus.duty_in = 8'd12; duty_bus.duty_valid = 1'b1;
      run(1,  10'h000, 10'h000, 10'h000, 1'b0, 1'b1, "flt_p0");
      duty_bus.duty_valid = 1'b0;
      run(8,  10'h000, 10'h000, 10'h000, 1'b0, 1'b1, "flt_p0");
      run(10, 10'b1111111100, 10'h000, 10'h3FF, 1'b0, 1'b1, "flt_p1");
      run(5,  10'h3FF, 10'h000, 10'h3FF, 1'b0, 1'b1, "flt_pre");
      fault = 1'b1;
      run(1,  10'h000, 10'h000, 10'h3FF, 1'b1, 1'b1, "flt_kill");
      fault = 1'b0;
      run(24, 10'h000, 10'h000, 10'h3FF, 1'b1, 1'b1, "flt_hold");
      do_reset();
      run(9,  10'h000, 10'h000, 10'h3FF, 1'b0, 1'b1, "flt_clear");
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Downstream consumer of the period counter: compares the free-running `count` against a double-buffered duty value and drives one complementary gate pair (high side / low side) with programmable dead time. Duty updates arrive over a valid/ready handshake and take effect only at period boundaries, so the output never glitches mid-period. One instance per inverter leg; the counter output and its `enable`/`max_count` are shared by all legs.

## Interface
- `WIDTH`, 8: counter/duty width; equal to the counter's `WIDTH`.
- `DT_WIDTH`, 6: dead-time field width, in `clk` cycles.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  same enable that advances the counter.
- `count`  in  WIDTH  counter value.
- `max_count`  in  WIDTH  counter terminal value.
- `duty_in`  in  WIDTH  new duty (high-side on while `count < duty`).
- `duty_valid`  in  1  `duty_in` valid.
- `duty_ready`  out  1  pending buffer empty.
- `dead_time`  in  DT_WIDTH  dead time in `clk` cycles; sampled on entry to DEAD.
- `gate_hi`  out  1  high-side gate.
- `gate_lo`  out  1  low-side gate.
- `period_start`  out  1  one-cycle pulse per period boundary.
- `fault`  in  1  gate-kill request (only with `PWM_DEADTIME_FAULT_EN`).
- `fault_latched`  out  1  fault sticky flag (only with `PWM_DEADTIME_FAULT_EN`).

## Operation
- Boundary event `bnd = enable && count == max_count`.
- Handshake: `duty_valid && duty_ready` stores `duty_in` into `duty_pend` and sets `pend_full`; `duty_ready = !pend_full`. On `bnd` with `pend_full`: `duty_act <= duty_pend`, `pend_full` cleared. Capture and `bnd` in the same cycle: value goes to `duty_pend`, applied at the next `bnd`.
- Demand `req = count < duty_act` (unsigned, combinational). `duty_act = 0` → 0 %; `duty_act > max_count` → 100 %.
- FSM states: IDLE (both off), DEAD (both off), HI (`gate_hi`), LO (`gate_lo`).
  - IDLE → DEAD on first `bnd`.
  - HI → DEAD when `!req`; LO → DEAD when `req`; `dt_cnt <= dead_time`.
  - DEAD: `dt_cnt` decrements every `clk` (not gated by `enable`); exit when `dt_cnt <= 1` to HI if `req` else LO. DEAD lasts max(`dead_time`, 1) cycles; `req` toggling during DEAD does not shorten it.
- `gate_hi`/`gate_lo` are decoded from the state register, never both high.
- Reset values: state IDLE, `gate_hi = gate_lo = 0`, `duty_act = duty_pend = 0`, `pend_full = 0`, `duty_ready = 1` (after reset release), `period_start = 0`, `dt_cnt = 0`, `fault_latched = 0`.
- Reset mid-operation: gates drop asynchronously; pending duty is discarded.

## Timing
- `period_start` registered: high the cycle after `bnd`.
- Gate turn-off: the state register changes on the first edge where `!req` (or `req`) is seen, so the gate falls 1 cycle after the crossing.
- Opposite-gate turn-on: `max(dead_time, 1)` cycles after turn-off.
- Duty latency: a value accepted in period k is active from the first cycle of period k+1.

## Configuration
- `PWM_DEADTIME_FAULT_EN` defined: `fault` and `fault_latched` ports are present. `fault` high forces state to IDLE at the next edge and sets `fault_latched`. While latched, the FSM stays in IDLE and `bnd` is ignored. Only `reset` clears the flag.
- Not defined: ports are absent; IDLE is left permanently after the first `bnd`.

## Structure
- Package `pwm_pkg`: state enum (IDLE, DEAD, HI, LO), default `DT_WIDTH`.
- Sub-module `dead_time_gen`: FSM plus `dt_cnt`; takes `req`, `start` (first `bnd`), `dead_time`; drives the gates.
- Duty buffer, handshake and compare stay in the top module.

## Test plan
- Reset, `max_count=9`, no duty written → gates 0 until the first `bnd`, then `gate_lo=1` after 1 DEAD cycle; `period_start` is a pulse every 10 enables.
- Duty 4, `dead_time=3`, `enable=1` every clk → per period `gate_hi` high for 4−3=1 cycle and `gate_lo` high for 6−3=3 cycles, with 3-cycle both-off gaps.
- Duty written mid-period, then a second `duty_valid` → `duty_ready=0` and the second write is stalled; the first value applies at the next boundary, and `duty_ready` returns to 1 the cycle after.
- Duty 0 and duty 12 with `max_count=9` → continuous `gate_lo` and continuous `gate_hi` respectively, no DEAD entries.
- `dead_time=0` → exactly 1 both-off cycle at each transition; assert `gate_hi && gate_lo` never true in any test.
- With `PWM_DEADTIME_FAULT_EN`: `fault` pulse while in HI → gates 0 next edge, `fault_latched=1`, which persists across boundaries until `reset`.
